mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one bus transfer per aligned LDW/STW through a
// request/grant/strobe/ready handshake and drives the MEM pipeline register.
module mem_stage (
    input  logic        clk,
    input  logic        reset_,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [29:0] EXPC,
    input  logic        EXEn,
    input  logic        EXBrFlag,
    input  logic [1:0]  EXMemOp,
    input  logic [31:0] EXMemWrData,
    input  logic [1:0]  EXCtrlOp,
    input  logic [4:0]  EXDstAddr,
    input  logic        EXGPRWE_,
    input  logic [2:0]  EXExpCode,
    input  logic [31:0] EXOut,
    output logic        BusReq_,
    input  logic        BusGrnt_,
    output logic        BusAs_,
    output logic        BusRw,
    output logic [29:0] BusAddr,
    output logic [31:0] BusWrData,
    input  logic [31:0] BusRdData,
    input  logic        BusRdy_,
    output logic        MEMBusy,
    output logic [29:0] MEMPC,
    output logic        MEMEn,
    output logic        MEMBrFlag,
    output logic [1:0]  MEMCtrlOp,
    output logic [4:0]  MEMDstAddr,
    output logic        MEMGPRWE_,
    output logic [2:0]  MEMExpCode,
    output logic [31:0] MEMOut
);

    localparam logic [1:0] MEM_OP_NOP         = 2'd0;
    localparam logic [1:0] MEM_OP_LDW         = 2'd1;
    localparam logic [1:0] MEM_OP_STW         = 2'd2;
    localparam logic [1:0] CTRL_OP_NOP        = 2'd0;
    localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
    localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'd4;
    localparam logic       READ     = 1'b1;
    localparam logic       WRITE    = 1'b0;
    localparam logic       ENABLE   = 1'b1;
    localparam logic       DISABLE  = 1'b0;
    localparam logic       ENABLE_  = 1'b0;
    localparam logic       DISABLE_ = 1'b1;

    typedef enum logic [1:0] {IDLE, REQ, ACCESS, DONE} state_t;

    state_t      state;
    logic        flush_pend;
    logic [31:0] rd_buf;
    logic        access_req;
    logic        miss_align;

    assign access_req = (EXEn == ENABLE) && (EXMemOp != MEM_OP_NOP) &&
                        (EXExpCode == ISA_EXP_NO_EXP) && (EXOut[1:0] == 2'b00) &&
                        (Flush == DISABLE);
    assign miss_align = (EXMemOp != MEM_OP_NOP) && (EXExpCode == ISA_EXP_NO_EXP) &&
                        (EXOut[1:0] != 2'b00);

    always_comb begin
        MEMBusy = 1'b0;
        unique case (state)
            IDLE:        MEMBusy = access_req;
            REQ, ACCESS: MEMBusy = 1'b1;
            default:     MEMBusy = 1'b0;
        endcase
    end

    // Bus outputs are registered on the transition into each state so that
    // they are glitch-free and drop asynchronously on reset.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state      <= IDLE;
            flush_pend <= 1'b0;
            rd_buf     <= '0;
            BusReq_    <= DISABLE_;
            BusAs_     <= DISABLE_;
            BusRw      <= READ;
            BusAddr    <= '0;
            BusWrData  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (access_req) begin
                        state   <= REQ;
                        BusReq_ <= ENABLE_;
                    end
                end
                REQ: begin
                    if (Flush != DISABLE) begin
                        state   <= IDLE;
                        BusReq_ <= DISABLE_;
                    end else if (!BusGrnt_) begin
                        state     <= ACCESS;
                        BusAs_    <= ENABLE_;
                        BusAddr   <= EXOut[31:2];
                        BusRw     <= (EXMemOp == MEM_OP_STW) ? WRITE : READ;
                        BusWrData <= (EXMemOp == MEM_OP_STW) ? EXMemWrData : '0;
                    end
                end
                ACCESS: begin
                    if (Flush != DISABLE) flush_pend <= 1'b1;
                    if (!BusRdy_) begin
                        state     <= DONE;
                        rd_buf    <= BusRdData;
                        BusReq_   <= DISABLE_;
                        BusAs_    <= DISABLE_;
                        BusRw     <= READ;
                        BusAddr   <= '0;
                        BusWrData <= '0;
                    end
                end
                DONE: begin
                    if (Flush != DISABLE) flush_pend <= 1'b1;
                    if (Stall == DISABLE) begin
                        state      <= IDLE;
                        flush_pend <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            MEMPC      <= '0;
            MEMEn      <= DISABLE;
            MEMBrFlag  <= DISABLE;
            MEMCtrlOp  <= CTRL_OP_NOP;
            MEMDstAddr <= '0;
            MEMGPRWE_  <= DISABLE_;
            MEMExpCode <= ISA_EXP_NO_EXP;
            MEMOut     <= '0;
        end else if (Stall == DISABLE) begin
            if ((Flush != DISABLE) || flush_pend) begin
                MEMPC      <= '0;
                MEMEn      <= DISABLE;
                MEMBrFlag  <= DISABLE;
                MEMCtrlOp  <= CTRL_OP_NOP;
                MEMDstAddr <= '0;
                MEMGPRWE_  <= DISABLE_;
                MEMExpCode <= ISA_EXP_NO_EXP;
                MEMOut     <= '0;
            end else if (miss_align) begin
                MEMPC      <= EXPC;
                MEMEn      <= EXEn;
                MEMBrFlag  <= EXBrFlag;
                MEMCtrlOp  <= CTRL_OP_NOP;
                MEMDstAddr <= '0;
                MEMGPRWE_  <= DISABLE_;
                MEMExpCode <= ISA_EXP_MISS_ALIGN;
                MEMOut     <= '0;
            end else begin
                MEMPC      <= EXPC;
                MEMEn      <= EXEn;
                MEMBrFlag  <= EXBrFlag;
                MEMCtrlOp  <= EXCtrlOp;
                MEMDstAddr <= EXDstAddr;
                MEMGPRWE_  <= EXGPRWE_;
                MEMExpCode <= EXExpCode;
                MEMOut     <= ((EXMemOp == MEM_OP_LDW) && (state == DONE)) ? rd_buf : EXOut;
            end
        end
    end

endmodule
